// File: rtl/spi_reg_cmd_ctrl.sv
// spi_reg_cmd_ctrl
// Command/register sequencer behind the SPI word serializer/deserializer.
// Each chip-select frame carries one command word {rnw, addr}, then a burst
// of data words. Write bursts become reg_wr strobes. Read bursts prefetch
// register data into tx_word, so the master shifts it out with the next
// (dummy) word.
//
// Ports
//   clk_in, reset_n          clock, asynchronous active-low reset
//   cs_active                frame-active level (synchronous to clk_in)
//   rx_word, rx_valid        received word and its one-cycle valid pulse
//   tx_word                  word presented for the next master read
//   reg_addr, reg_wdata      register-bus address / write data
//   reg_wr, reg_rd           one-cycle register-bus strobes
//   reg_rdata                read data, valid one cycle after reg_rd
//   err_overrun              sticky: word arrived while a fetch was in flight
//   burst_lim                sticky: MAX_BURST data words reached this frame
//
// state      | meaning
// -----------+--------------------------------------------------------
// IDLE       | no frame; flags and burst count cleared on frame start
// CMD        | waiting for the command word
// WRITE      | each data word produces one register write
// RD_ISSUE   | reg_rd is high this cycle
// RD_CAPTURE | reg_rdata valid; loaded into tx_word
// RD_WAIT    | prefetched word waits for the master's dummy word
module spi_reg_cmd_ctrl #(
   parameter int SPI_WORDLEN = 8,
   parameter int MAX_BURST   = 256,
   parameter bit AUTO_INC    = 1'b1
) (
   input  logic                   clk_in,
   input  logic                   reset_n,
   input  logic                   cs_active,
   input  logic [SPI_WORDLEN-1:0] rx_word,
   input  logic                   rx_valid,
   output logic [SPI_WORDLEN-1:0] tx_word,
   output logic [SPI_WORDLEN-2:0] reg_addr,
   output logic [SPI_WORDLEN-1:0] reg_wdata,
   output logic                   reg_wr,
   output logic                   reg_rd,
   input  logic [SPI_WORDLEN-1:0] reg_rdata,
   output logic                   err_overrun,
   output logic                   burst_lim
);

   localparam int AW = SPI_WORDLEN - 1;
   localparam int CW = $clog2(MAX_BURST) + 1;
   localparam logic [AW-1:0] ADDR_STEP = {{(AW-1){1'b0}}, AUTO_INC};
   localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      CMD        = 3'd1,
      WRITE      = 3'd2,
      RD_ISSUE   = 3'd3,
      RD_CAPTURE = 3'd4,
      RD_WAIT    = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [AW-1:0]          addr_q, addr_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [SPI_WORDLEN-1:0] tx_q, tx_d;
   logic [AW-1:0]          raddr_q, raddr_d;
   logic [SPI_WORDLEN-1:0] wdata_q, wdata_d;
   logic                   wr_q, wr_d;
   logic                   rd_q, rd_d;
   logic                   ovr_q, ovr_d;
   logic                   lim_q, lim_d;

   logic [AW-1:0]          addr_nxt;
   logic [CW-1:0]          cnt_inc;

   assign addr_nxt = addr_q + ADDR_STEP;   // wraps modulo 2^AW by width
   assign cnt_inc  = cnt_q + CW'(1);

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         tx_q    <= '0;
         raddr_q <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         rd_q    <= 1'b0;
         ovr_q   <= 1'b0;
         lim_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
         raddr_q <= raddr_d;
         wdata_q <= wdata_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         ovr_q   <= ovr_d;
         lim_q   <= lim_d;
      end
   end

   // reg_rd is registered: it is raised on entry to RD_ISSUE, so it is high
   // for exactly the cycle the FSM spends in RD_ISSUE.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      raddr_d = raddr_q;
      wdata_d = wdata_q;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
      ovr_d   = ovr_q;
      lim_d   = lim_q;

      if (!cs_active) begin
         // Frame end wins over any coincident word; a pending capture is lost.
         state_d = IDLE;
         tx_d    = '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = CMD;
               ovr_d   = 1'b0;
               lim_d   = 1'b0;
               cnt_d   = '0;
            end
            CMD: begin
               if (rx_valid) begin
                  addr_d = rx_word[AW-1:0];
                  if (rx_word[SPI_WORDLEN-1]) begin
                     state_d = RD_ISSUE;
                     rd_d    = 1'b1;
                     raddr_d = rx_word[AW-1:0];
                  end else begin
                     state_d = WRITE;
                  end
               end
            end
            WRITE: begin
               if (rx_valid && !lim_q) begin
                  wr_d    = 1'b1;
                  wdata_d = rx_word;
                  raddr_d = addr_q;
                  addr_d  = addr_nxt;
                  cnt_d   = cnt_inc;
                  if (cnt_inc == BURST_MAX) lim_d = 1'b1;
               end
            end
            RD_ISSUE: begin
               state_d = RD_CAPTURE;
               if (rx_valid) ovr_d = 1'b1;
            end
            RD_CAPTURE: begin
               state_d = RD_WAIT;
               tx_d    = reg_rdata;
               if (rx_valid) ovr_d = 1'b1;
            end
            RD_WAIT: begin
               if (rx_valid && !lim_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == BURST_MAX) begin
                     // Last word of the allowed burst: no further prefetch,
                     // tx_word keeps the data already shifted out.
                     lim_d = 1'b1;
                  end else begin
                     addr_d  = addr_nxt;
                     raddr_d = addr_nxt;
                     rd_d    = 1'b1;
                     state_d = RD_ISSUE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign tx_word     = tx_q;
   assign reg_addr    = raddr_q;
   assign reg_wdata   = wdata_q;
   assign reg_wr      = wr_q;
   assign reg_rd      = rd_q;
   assign err_overrun = ovr_q;
   assign burst_lim   = lim_q;

endmodule

// File: doc/spi_reg_cmd_ctrl.md
Name: spi_reg_cmd_ctrl

Overview:
- Command/register sequencer behind the SPI slave word serializer/deserializer in the sound core.
- Decodes the word stream of each chip-select frame into one command word followed by a burst of data words.
- Converts the burst into single-cycle register-bus writes or reads with address auto-increment.
- Prefetches read data into the serializer's transmit word so the master can read it back.

Parameters:
- SPI_WORDLEN, 8: word width; must match the serializer. Command word = {rnw, addr[SPI_WORDLEN-2:0]}.
- MAX_BURST, 256: maximum data words accepted per frame; later words are ignored.
- AUTO_INC, 1'b1: 1 = address increments after each data word; 0 = address held fixed (FIFO-style register).

Ports:
- clk_in, input, 1: system clock.
- reset_n, input, 1: asynchronous, active-low reset.
- cs_active, input, 1: frame-active level from the serializer, synchronous to clk_in.
- rx_word, input, SPI_WORDLEN: word received from the master.
- rx_valid, input, 1: one-cycle pulse; rx_word is complete and valid.
- tx_word, output, SPI_WORDLEN: word handed to the serializer for the next master read.
- reg_addr, output, SPI_WORDLEN-1: register-bus address.
- reg_wdata, output, SPI_WORDLEN: register-bus write data.
- reg_wr, output, 1: one-cycle write strobe.
- reg_rd, output, 1: one-cycle read strobe.
- reg_rdata, input, SPI_WORDLEN: read data, valid exactly 1 cycle after reg_rd.
- err_overrun, output, 1: sticky; a word arrived while a read fetch was in flight.
- burst_lim, output, 1: sticky; MAX_BURST was reached in this frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; address register 0; burst counter 0.
- States:
  - IDLE: on cs_active=1 → CMD. Clear err_overrun, burst_lim and the burst counter on this transition.
  - CMD: on rx_valid, latch addr = rx_word[SPI_WORDLEN-2:0]. If rx_word[SPI_WORDLEN-1]=0 → WRITE. If 1 → RD_ISSUE.
  - WRITE: on each rx_valid, drive reg_wr=1, reg_wdata=rx_word, reg_addr=addr in the next cycle (1-cycle latency). Then add 1 to addr if AUTO_INC.
  - RD_ISSUE: drive reg_rd=1 with reg_addr=addr for one cycle → RD_CAPTURE.
  - RD_CAPTURE: tx_word <= reg_rdata → RD_WAIT. tx_word is therefore valid 2 cycles after the command word's rx_valid.
  - RD_WAIT: on rx_valid (dummy word shifted in, data shifted out), count the word. Add 1 to addr if AUTO_INC → RD_ISSUE. The prefetch for the next word completes in 2 cycles.
- Address arithmetic: addr is SPI_WORDLEN-1 bits and wraps modulo 2^(SPI_WORDLEN-1), e.g. 7F → 00. No flag is raised on wrap.
- Burst counter:
  - Counts data words (the command word is excluded). Width is $clog2(MAX_BURST)+1.
  - When the count equals MAX_BURST, set burst_lim=1 and suppress further reg_wr/reg_rd in this frame.
  - tx_word holds its last value while burst_lim=1. State stays in place until the frame ends.
- Overrun: rx_valid during RD_ISSUE or RD_CAPTURE sets err_overrun=1 and the word is dropped, not counted. The in-flight fetch completes normally.
- Frame end: cs_active=0 in any state → IDLE on the next cycle.
  - The same cycle drives reg_wr=0, reg_rd=0 and tx_word=0.
  - An rx_valid coincident with cs_active falling is ignored.
  - An in-flight read capture is discarded.
  - err_overrun and burst_lim hold until the next frame start.
- cs_active=1 with no rx_valid: the state holds indefinitely. No timeout.
- reg_wr and reg_rd are never asserted together. Each asserts at most once per rx_valid.
- Asynchronous reset mid-frame returns to IDLE immediately. A frame still active after reset release is entered at CMD, i.e. the next word is treated as a command.

Test Plan:
- Write burst: cs=1; words 0x10, 0xAA, 0xBB → reg_wr pulses (addr 0x10, data 0xAA) then (0x11, 0xBB); reg_rd never asserted.
- Read burst: register model returns addr^0x55; words 0x85, dummy, dummy → reg_rd at 0x05, 0x06, 0x07; tx_word = 0x50, then 0x53, then 0x52, each within 2 cycles of the prior rx_valid.
- Wrap and AUTO_INC=0: write command at 0x7F with 2 data words → addresses 0x7F, 0x00; with AUTO_INC=0 → both 0x7F.
- Abort: cs drops after the first write data word, with rx_valid coincident → exactly one reg_wr; state IDLE; tx_word=0; next frame's first word is decoded as a command.
- Overrun: read command, then rx_valid one cycle after reg_rd → err_overrun=1; word dropped; reg_rd count unchanged; flag clears at the next frame start.
- Burst limit: MAX_BURST=4, write command + 6 data words → exactly 4 reg_wr; burst_lim=1 after the 4th; cleared at the next frame start.
